// File: rtl/clk_sched_pkg.sv
// Shared types and tap-edge helper for the multi-channel tick scheduler.
package clk_sched_pkg;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_RUN  = 2'd1,
    CH_PEND = 2'd2
  } ch_state_e;

  // Widest prescaler the helper supports; narrower counters are zero-extended.
  localparam int MAX_W = 64;

  // True in the cycle before bit s of the counter goes 0->1.
  function automatic logic tap_rise(input logic [MAX_W-1:0] c, input logic [5:0] s);
    logic [MAX_W-1:0] low_mask;
    low_mask = (MAX_W'(1) << s) - MAX_W'(1);
    return (c[s] == 1'b0) && ((c & low_mask) == low_mask);
  endfunction

endpackage

// File: rtl/clk_tick_chan.sv
// One tick channel: run/pending FSM, live tap select, shadow config, tick strobe.
module clk_tick_chan
  import clk_sched_pkg::*;
#(
  parameter  int SEL_W = 5,
  localparam int NSEL  = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [NSEL-1:0]  rise,
  output logic             tick,
  output logic             active,
  output logic             pend
);

  ch_state_e        state;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] sh_sel;
  logic             sh_en;
  logic             tick_p1;
  logic             rise_cur;
  logic             rise_new;

  assign rise_cur = rise[sel];
  assign rise_new = rise[wr_sel];

  // Stage p1: tick register and channel state update
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CH_OFF;
      sel     <= '0;
      sh_sel  <= '0;
      sh_en   <= 1'b0;
      tick_p1 <= 1'b0;
    end else begin
      tick_p1 <= 1'b0;
      case (state)
        CH_OFF: begin
          // A start that lands on the new tap's rise ticks right away: still a full-period phase.
          if (wr && wr_en) begin
            sel     <= wr_sel;
            state   <= CH_RUN;
            tick_p1 <= rise_new;
          end
        end
        CH_RUN: begin
          tick_p1 <= rise_cur;
          if (wr) begin
            if (rise_cur) begin
              if (wr_en) sel <= wr_sel;
              else       state <= CH_OFF;
            end else begin
              sh_en  <= wr_en;
              sh_sel <= wr_sel;
              state  <= CH_PEND;
            end
          end
        end
        CH_PEND: begin
          tick_p1 <= rise_cur;
          if (rise_cur) begin
            if (sh_en) begin
              sel   <= sh_sel;
              state <= CH_RUN;
            end else begin
              state <= CH_OFF;
            end
          end
        end
        default: state <= CH_OFF;
      endcase
    end
  end

  assign tick   = tick_p1;
  assign active = (state != CH_OFF);
  assign pend   = (state == CH_PEND);

endmodule

// File: rtl/clk_tick_sched.sv
// Shared free-running prescaler feeding NUM_CH glitch-free retunable tick channels.
module clk_tick_sched
  import clk_sched_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_en,
  input  logic [SEL_W-1:0]  cfg_sel,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active,
  output logic [WIDTH-1:0]  count_o
);

  localparam int NSEL    = 1 << SEL_W;
  localparam int NCH_EXT = 1 << CH_W;

  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   rise_vec;
  logic [NSEL-1:0]    rise_ext;
  logic [NUM_CH-1:0]  pend;
  logic [NCH_EXT-1:0] pend_ext;
  logic               cfg_fire;

  // Stage p0: prescaler counter
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (ena) cnt <= cnt + WIDTH'(1);
  end

  assign count_o = cnt;

  for (genvar s = 0; s < WIDTH; s++) begin : g_rise
    assign rise_vec[s] = ena && tap_rise(MAX_W'(cnt), 6'(s));
  end

  // Out-of-range tap codes alias the top bit, which is the clamp to WIDTH-1.
  for (genvar s = 0; s < NSEL; s++) begin : g_rise_ext
    if (s < WIDTH) begin : g_in
      assign rise_ext[s] = rise_vec[s];
    end else begin : g_clamp
      assign rise_ext[s] = rise_vec[WIDTH-1];
    end
  end

  // Unpopulated channel indices are never pending, so writes to them are accepted and dropped.
  for (genvar c = 0; c < NCH_EXT; c++) begin : g_pend_ext
    if (c < NUM_CH) begin : g_in
      assign pend_ext[c] = pend[c];
    end else begin : g_none
      assign pend_ext[c] = 1'b0;
    end
  end

  assign cfg_ready = ~pend_ext[cfg_ch];
  assign cfg_fire  = cfg_valid && cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_tick_chan #(
      .SEL_W (SEL_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .wr     (cfg_fire && (cfg_ch == CH_W'(i))),
      .wr_en  (cfg_en),
      .wr_sel (cfg_sel),
      .rise   (rise_ext),
      .tick   (tick[i]),
      .active (active[i]),
      .pend   (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_tick_sched.sv
// Bench for clk_tick_sched: vector table, directed corner sequences, randomized run vs model.
module tb_clk_tick_sched;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, ena, cfg_valid, cfg_en, cfg_ready;
  logic [1:0]   cfg_ch;
  logic [2:0]   cfg_sel;
  logic [N-1:0] tick, active;
  logic [W-1:0] count_o;

  clk_tick_sched #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_en    (cfg_en),
    .cfg_sel   (cfg_sel),
    .tick      (tick),
    .active    (active),
    .count_o   (count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit live  = 1'b0;

  // Reference: channel is off (sel=-1) or runs at a tap; a retune waits in a one-entry pending slot.
  int         m_cnt;
  int         m_sel[N];
  bit         m_pend[N];
  bit         m_pen_en[N];
  int         m_pen_sel[N];
  logic [N-1:0] m_tick;

  typedef struct {
    logic       v;
    logic [1:0] ch;
    logic       en;
    logic [2:0] sel;
    logic [3:0] x_tick;
    logic [3:0] x_act;
    logic       x_rdy;
    logic [7:0] x_cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (model cnt=%0d)", nm, act, exp, m_cnt);
    end
  endtask

  function automatic bit bit_up(input int c, input int n, input int s);
    return (((c >> s) & 1) == 0) && (((n >> s) & 1) == 1);
  endfunction

  task automatic model_step();
    int nxt;
    bit acc;
    int s;
    bit t;
    if (rst) begin
      m_cnt  = 0;
      m_tick = '0;
      for (int i = 0; i < N; i++) begin
        m_sel[i]  = -1;
        m_pend[i] = 1'b0;
      end
      return;
    end
    nxt = ena ? (m_cnt + 1) % (1 << W) : m_cnt;
    acc = cfg_valid && !m_pend[cfg_ch];
    s   = (int'(cfg_sel) > W - 1) ? W - 1 : int'(cfg_sel);
    for (int i = 0; i < N; i++) begin
      t = 1'b0;
      if (m_sel[i] >= 0) begin
        t = bit_up(m_cnt, nxt, m_sel[i]);
        if (m_pend[i]) begin
          if (t) begin
            m_sel[i]  = m_pen_en[i] ? m_pen_sel[i] : -1;
            m_pend[i] = 1'b0;
          end
        end else if (acc && int'(cfg_ch) == i) begin
          if (t) m_sel[i] = cfg_en ? s : -1;
          else begin
            m_pend[i]    = 1'b1;
            m_pen_en[i]  = cfg_en;
            m_pen_sel[i] = s;
          end
        end
      end else if (acc && int'(cfg_ch) == i && cfg_en) begin
        m_sel[i] = s;
        t = bit_up(m_cnt, nxt, s);
      end
      m_tick[i] = t;
    end
    m_cnt = nxt;
  endtask

  task automatic drive(input logic r, input logic e, input logic v, input logic [1:0] ch,
                       input logic en, input logic [2:0] sel);
    logic [N-1:0] ea;
    rst = r; ena = e; cfg_valid = v; cfg_ch = ch; cfg_en = en; cfg_sel = sel;
    #1;
    if (live) begin
      for (int i = 0; i < N; i++) ea[i] = (m_sel[i] >= 0);
      chk("model_count", 32'(count_o), 32'(m_cnt));
      chk("model_tick", 32'(tick), 32'(m_tick));
      chk("model_active", 32'(active), 32'(ea));
      chk("model_ready", 32'(cfg_ready), 32'(!m_pend[cfg_ch]));
    end
  endtask

  task automatic advance();
    model_step();
    live = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic e, input logic v, input logic [1:0] ch,
                      input logic en, input logic [2:0] sel);
    drive(r, e, v, ch, en, sel);
    advance();
  endtask

  task automatic idle(input logic [1:0] ch);
    step(1'b0, 1'b1, 1'b0, ch, 1'b0, 3'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0);
  endtask

  task automatic run_to(input int c, input logic [1:0] ch);
    int n = 0;
    while (m_cnt != c && n < 600) begin
      idle(ch);
      n++;
    end
    if (m_cnt != c) begin
      total++;
      bad++;
      $display("FAIL run_to: count stuck at %0d, want %0d", m_cnt, c);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench timed out");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 1'b1, 3'd0, 4'b0000, 4'b0000, 1'b1, 8'd0};
    tbl[1]  = '{1'b1, 2'd1, 1'b1, 3'd2, 4'b0001, 4'b0001, 1'b1, 8'd1};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 3'd0, 4'b0000, 4'b0011, 1'b1, 8'd2};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 3'd0, 4'b0001, 4'b0011, 1'b1, 8'd3};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 3'd0, 4'b0010, 4'b0011, 1'b1, 8'd4};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 3'd0, 4'b0001, 4'b0011, 1'b1, 8'd5};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 3'd0, 4'b0000, 4'b0011, 1'b1, 8'd6};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 3'd0, 4'b0001, 4'b0011, 1'b1, 8'd7};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 3'd0, 4'b0000, 4'b0011, 1'b1, 8'd8};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 3'd0, 4'b0001, 4'b0011, 1'b1, 8'd9};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 3'd0, 4'b0000, 4'b0011, 1'b0, 8'd10};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 3'd0, 4'b0001, 4'b0010, 1'b1, 8'd11};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 3'd0, 4'b0010, 4'b0010, 1'b1, 8'd12};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 3'd0, 4'b0000, 4'b0010, 1'b1, 8'd13};

    @(negedge clk);
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 3'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    do_reset();

    // Table: ch0 sel0 and ch1 sel2 from reset, then a deferred stop of ch0.
    for (int k = 0; k < 14; k++) begin
      drive(1'b0, 1'b1, tbl[k].v, tbl[k].ch, tbl[k].en, tbl[k].sel);
      chk($sformatf("tbl%0d_count", k), 32'(count_o), 32'(tbl[k].x_cnt));
      chk($sformatf("tbl%0d_tick", k), 32'(tick), 32'(tbl[k].x_tick));
      chk($sformatf("tbl%0d_active", k), 32'(active), 32'(tbl[k].x_act));
      chk($sformatf("tbl%0d_ready", k), 32'(cfg_ready), 32'(tbl[k].x_rdy));
      advance();
    end

    // Retune sel3 -> sel1 at cnt=5: old-tap tick at 8, then 10, 14, 18.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 3'd3);
    run_to(5, 2'd1);
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 3'd1);
    for (int c = 6; c <= 18; c++) begin
      drive(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 3'd0);
      chk($sformatf("s3_tick_c%0d", c), 32'(tick[1]),
          32'(c == 8 || c == 10 || c == 14 || c == 18));
      chk($sformatf("s3_ready_c%0d", c), 32'(cfg_ready), 32'(c >= 8));
      advance();
    end

    // Stop sel7 at cnt=3: last tick at 128, silent across the wrap.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 3'd7);
    run_to(3, 2'd2);
    step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 3'd0);
    for (int k = 0; k < 300; k++) begin
      chk("s4_tick", 32'(tick[2]), 32'(k == 124));
      chk("s4_active", 32'(active[2]), 32'(k < 124));
      idle(2'd2);
    end

    // Pending ch3 through a 10-cycle ena freeze.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 3'd2);
    run_to(5, 2'd3);
    step(1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 3'd0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 3'd0);
      chk("s5_frozen_count", 32'(count_o), 32'd6);
      chk("s5_frozen_tick", 32'(tick), 32'd0);
      chk("s5_frozen_ready", 32'(cfg_ready), 32'd0);
      advance();
    end
    run_to(12, 2'd3);
    chk("s5_old_tap_tick", 32'(tick[3]), 32'd1);
    chk("s5_ready_back", 32'(cfg_ready), 32'd1);
    idle(2'd3);
    chk("s5_new_tick13", 32'(tick[3]), 32'd1);
    idle(2'd3);
    chk("s5_new_tick14", 32'(tick[3]), 32'd0);
    idle(2'd3);
    chk("s5_new_tick15", 32'(tick[3]), 32'd1);

    // Reset while ch1 is pending, then restart at sel0.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 3'd2);
    run_to(5, 2'd1);
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 3'd1);
    chk("s6_pend_ready", 32'(cfg_ready), 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 3'd0);
    chk("s6_count", 32'(count_o), 32'd0);
    chk("s6_tick", 32'(tick), 32'd0);
    chk("s6_active", 32'(active), 32'd0);
    chk("s6_ready", 32'(cfg_ready), 32'd1);
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 3'd0);
    chk("s6_first_tick", 32'(tick[1]), 32'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step(1'b0 || ($urandom_range(0, 199) == 0),
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 3,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0,
           ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7)));
    end
    idle(2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_tick_sched.md
Name: clk_tick_sched

Overview:
Multi-channel tick scheduler built around a shared free-running prescaler counter. Each of NUM_CH channels selects one counter bit (tap) and receives a single-cycle tick strobe on every rising edge of that bit. Retuning or disabling a running channel takes effect only at that channel's next natural edge, so consumers never see a runt or doubled tick. Sits in the Peripheral_Unit and supplies timebase enables to UART, PWM and timer blocks.

Parameters:
WIDTH, 32, prescaler counter width in bits.
NUM_CH, 4, number of tick channels.
SEL_W, $clog2(WIDTH), tap-select width (derived; not overridden).
CH_W, $clog2(NUM_CH) (min 1), channel-index width (derived).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
ena  in  1  global count enable; counter and all edges freeze while low.
cfg_valid  in  1  configuration request.
cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
cfg_ch  in  CH_W  target channel.
cfg_en  in  1  1 = run the channel, 0 = stop it.
cfg_sel  in  SEL_W  tap index s; tick period = 2^(s+1) enabled cycles.
tick  out  NUM_CH  per-channel one-cycle strobe, registered.
active  out  NUM_CH  channel state != CH_OFF.
count_o  out  WIDTH  prescaler counter value.

Behaviour:
- Reset: cnt=0, tick=0, all channels CH_OFF, shadow registers 0, active=0, cfg_ready=1.
- Counter: cnt increments by 1 when ena=1 and holds otherwise. It wraps from 2^WIDTH-1 to 0.
- rise(s) = ena && cnt[s]==0 && (s==0 || &cnt[s-1:0]). This is the cycle before cnt[s] goes 0->1.
- Tick latency: tick[i] is asserted the cycle after rise(sel_i), which is the first cycle cnt[sel_i]==1. A wrap (bit falling) produces no tick.
- cfg_sel >= WIDTH is clamped to WIDTH-1.
- cfg_ready = (state[cfg_ch] != CH_PEND). It is combinational from registered state. If cfg_ch >= NUM_CH, cfg_ready=1 and the write is accepted and discarded.
- Channel FSM (per channel; state, sel and shadow {en, sel}):
  - CH_OFF + accepted write with en=1: load sel and go to CH_RUN. The first tick follows the next rise(sel), so it is phase-aligned with no partial period.
  - CH_OFF + accepted write with en=0: no change.
  - CH_RUN + accepted write, no rise(sel) in the same cycle: load shadow and go to CH_PEND. Ticks continue on the old sel.
  - CH_RUN + accepted write in the same cycle as rise(sel): the tick for that rise is emitted using the old sel. The new config applies directly: en=1 loads sel and stays in CH_RUN; en=0 goes to CH_OFF.
  - CH_PEND + rise(sel): the tick is emitted on the old sel. Then shadow en=1 loads sel from shadow and goes to CH_RUN; shadow en=0 goes to CH_OFF. cfg_ready for this channel returns high the following cycle.
  - CH_PEND + ena=0: the channel waits indefinitely. There is no timeout.
- Channels are independent. Writes to different channels in consecutive cycles are all accepted.
- rst has priority over everything, including mid-PEND. The next cycle shows the reset values.

Decomposition:
- Package clk_sched_pkg:
  - enum ch_state_e {CH_OFF, CH_RUN, CH_PEND}, 2-bit.
  - Function computing rise(cnt, s) for a given width.
- Sub-module clk_tick_chan: per-channel FSM, sel and shadow registers, tick register. Instantiated NUM_CH times in a generate loop.
- Counter, cfg_ready mux and cfg_ch decode live inline in the top level.

Test Plan:
(All scenarios use WIDTH=8, NUM_CH=4, ena=1 unless stated.)
1. After reset, write ch0 en=1 sel=0 while cnt=0 -> tick[0] high whenever cnt is odd (1, 3, 5, ...), 1-cycle pulses, active[0]=1.
2. Write ch1 en=1 sel=2 -> tick[1] high exactly when cnt=4, 12, 20, ...; period 8. No tick at cnt=0 after a wrap.
3. ch1 running sel=3; write sel=1 at cnt=5 -> cfg_ready low for ch1 until the tick at cnt=8; next ticks at cnt=10, 14, 18; no extra tick between 8 and 10.
4. ch2 running sel=7; write en=0 at cnt=3 -> one final tick at cnt=128, then active[2]=0 and no further ticks across a full 256-count wrap.
5. ch3 in CH_PEND; drop ena for 10 cycles -> count_o frozen, no ticks on any channel, ch3 remains pending with cfg_ready=0 while cfg_ch=3. Restore ena -> pending config applies at the next old-tap rise.
6. Assert rst for 1 cycle while ch1 is in CH_PEND -> next cycle count_o=0, tick=0, active=0, cfg_ready=1. A new write to ch1 sel=0 gives its first tick at cnt=1.
